work_packer: RTL and testbench
==============================

# work_packer

Upstream stage of the 256-bit work FIFO: accepts 32-bit beats from the host-side loader over a valid/ready handshake and assembles eight beats into one 256-bit work word. It presents each completed word to the FIFO write port, with `fifo_wr_en` gated by `fifo_full`. It also detects framing errors, resynchronises on the `in_last` marker, and counts words written.

## Interface
- `DATA_WIDTH`, 256, assembled word width (FIFO data width).
- `BEAT_WIDTH`, 32, input beat width.
- `BEATS`, 8, beats per word (`DATA_WIDTH/BEAT_WIDTH`).
- `BEAT_CNT_LOG2`, 3, width of beat counter.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: beat valid.
- `in_data` in `BEAT_WIDTH`: beat payload.
- `in_last` in 1: beat is final beat of a word.
- `in_ready` out 1: packer accepts a beat this cycle.
- `fifo_full` in 1: FIFO full flag.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_data` out `DATA_WIDTH`: word to FIFO.
- `frame_err` out 1: one-cycle pulse on framing error.
- `words_pushed` out 16: count of words written, wraps.

## Operation
- Beat accepted on a rising edge where `in_valid && in_ready`.
- State machine: `COLLECT`, `PUSH`, `DROP`. `in_ready = (state != PUSH)`.
- **`COLLECT`:** beat k (k = beat count, 0..7) is written to `fifo_data[DATA_WIDTH-1-32k -: 32]`, so beat 0 lands in the MSBs. On accept:
  - k<7, `in_last`=0: count++.
  - k<7, `in_last`=1: `frame_err` pulse, count←0, partial word discarded, stay `COLLECT`.
  - k=7, `in_last`=1: count←0, →`PUSH`.
  - k=7, `in_last`=0: `frame_err` pulse, count←0, →`DROP`; assembled word discarded.
- **`PUSH`:**
  - `fifo_wr_en = !fifo_full` (combinational).
  - On an edge with `fifo_wr_en`=1: `words_pushed`++ (mod 2^16), →`COLLECT`.
  - `fifo_data` is held stable throughout `PUSH`.
- **`DROP`:** beats accepted and discarded; accepting a beat with `in_last`=1 →`COLLECT`. No further `frame_err` in `DROP`.
- `fifo_wr_en` is 0 in every state other than `PUSH`.

## Timing
- Reset values (asynchronous, while `resetn`=0): state `COLLECT`, count 0, `fifo_data` 0, `frame_err` 0, `words_pushed` 0. Hence `in_ready`=1 and `fifo_wr_en`=0.
- Upstream must hold `in_valid`=0 during reset.
- Reset mid-word or mid-`PUSH`: the word is lost; no write occurs after `resetn` falls.
- Latency:
  - 8th beat accepted at edge N.
  - `fifo_wr_en`=1 in cycle N..N+1 if `fifo_full`=0.
  - FIFO captures the word at edge N+1.
  - `in_ready`=1 again from edge N+1.
- Peak throughput: 1 word per 9 cycles.
- Back-pressure: `fifo_full`=1 holds `PUSH` indefinitely with `in_ready`=0. The write occurs on the first edge after `fifo_full` drops.
- `frame_err` is registered: it asserts the cycle after the offending beat's accept edge, for exactly one cycle.
- `fifo_wr_en` never asserts while `fifo_full`=1, so the FIFO never sees a dropped write.

## Configuration
- `WORK_PACKER_BYTESWAP_EN` defined: each beat is byte-reversed before placement (`in_data[7:0]` → beat MSByte), converting little-endian host words to the big-endian hashing order.
- Not defined: beats are placed unmodified.
- Framing, handshake and timing are identical in both builds.

## Test plan
- Reset, then beats `0x00000000`..`0x00000007` with `in_last` on beat 7 and `fifo_full`=0:
  - `fifo_wr_en` is high one cycle, 1 cycle after the last accept.
  - `fifo_data = 0x00000000_00000001_..._00000007`.
  - `words_pushed`=1.
- Same word with `fifo_full`=1 for 5 cycles after the last accept:
  - `in_ready`=0 and `fifo_wr_en`=0 for those 5 cycles.
  - Single write on the 6th cycle with the word unchanged.
- `in_last` on beat 3:
  - `frame_err` pulses once; no write.
  - A following clean 8-beat word is written correctly; `words_pushed`=1.
- 8 beats without `in_last`, then 2 more beats with `in_last` on the second:
  - One `frame_err`; no write.
  - Next clean word is written.
- Assert `resetn`=0 after beat 5, release, then send a clean word:
  - Only the new word is written.
  - `words_pushed`=1; `fifo_data` holds no stale beats.
- `WORK_PACKER_BYTESWAP_EN` build, beat 0 = `0x11223344`:
  - `fifo_data[255:224] = 0x44332211`.
  - Non-macro build gives `0x11223344`.

Source files
------------

// File: rtl/work_packer.sv
// Packs eight 32-bit beats into one 256-bit work word and writes it to the work FIFO.
// Optional build macro WORK_PACKER_BYTESWAP_EN byte-reverses each beat before placement.
module work_packer #(
    parameter int DATA_WIDTH    = 256,
    parameter int BEAT_WIDTH    = 32,
    parameter int BEATS         = 8,
    parameter int BEAT_CNT_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [BEAT_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  frame_err,
    output logic [15:0]           words_pushed
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PUSH    = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [BEAT_CNT_LOG2-1:0] cnt_r;
    logic [BEAT_CNT_LOG2-1:0] cnt_next_s;
    logic [DATA_WIDTH-1:0]    data_r;
    logic [DATA_WIDTH-1:0]    data_next_s;
    logic                     frame_err_r;
    logic                     frame_err_next_s;
    logic [15:0]              words_r;
    logic                     accept_s;
    logic                     last_slot_s;
    logic [BEAT_WIDTH-1:0]    beat_s;

    function automatic logic [BEAT_WIDTH-1:0] byte_reverse(input logic [BEAT_WIDTH-1:0] d);
        logic [BEAT_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < BEAT_WIDTH / 8; b++) begin
            r[8*b +: 8] = d[BEAT_WIDTH-8-8*b +: 8];
        end
        return r;
    endfunction

`ifdef WORK_PACKER_BYTESWAP_EN
    assign beat_s = byte_reverse(in_data);
`else
    assign beat_s = in_data;
`endif

    assign accept_s     = in_valid && in_ready;
    assign last_slot_s  = (cnt_r == BEAT_CNT_LOG2'(BEATS - 1));
    assign fifo_data    = data_r;
    assign frame_err    = frame_err_r;
    assign words_pushed = words_r;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, beat counter and framing-error decode.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        frame_err_next_s = 1'b0;
        case (state_r)
            COLLECT: begin
                if (accept_s) begin
                    if (last_slot_s) begin
                        cnt_next_s = '0;
                        if (in_last) begin
                            state_next_s = PUSH;
                        end else begin
                            frame_err_next_s = 1'b1;
                            state_next_s     = DROP;
                        end
                    end else if (in_last) begin
                        frame_err_next_s = 1'b1;
                        cnt_next_s       = '0;
                    end else begin
                        cnt_next_s = cnt_r + BEAT_CNT_LOG2'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = PUSH;
                end
            end
            DROP: begin
                if (accept_s && in_last) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: begin
                state_next_s = COLLECT;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Handshake and FIFO strobe; the strobe follows fifo_full directly so no write is ever dropped.
    always_comb begin
        in_ready   = 1'b1;
        fifo_wr_en = 1'b0;
        case (state_r)
            COLLECT: begin
                in_ready   = 1'b1;
                fifo_wr_en = 1'b0;
            end
            PUSH: begin
                in_ready   = 1'b0;
                fifo_wr_en = !fifo_full;
            end
            DROP: begin
                in_ready   = 1'b1;
                fifo_wr_en = 1'b0;
            end
            default: begin
                in_ready   = 1'b0;
                fifo_wr_en = 1'b0;
            end
        endcase
    end

    // Beat k lands in slot k counted from the MSB end of the word.
    always_comb begin
        data_next_s = data_r;
        for (int i = 0; i < BEATS; i++) begin
            if (accept_s && (state_r == COLLECT) && (cnt_r == BEAT_CNT_LOG2'(i))) begin
                data_next_s[(BEATS-1-i)*BEAT_WIDTH +: BEAT_WIDTH] = beat_s;
            end else begin
                data_next_s[(BEATS-1-i)*BEAT_WIDTH +: BEAT_WIDTH] =
                    data_r[(BEATS-1-i)*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Datapath, error pulse and push counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r       <= '0;
            data_r      <= '0;
            frame_err_r <= 1'b0;
            words_r     <= 16'd0;
        end else begin
            cnt_r       <= cnt_next_s;
            data_r      <= data_next_s;
            frame_err_r <= frame_err_next_s;
            if (fifo_wr_en) begin
                words_r <= words_r + 16'd1;
            end else begin
                words_r <= words_r;
            end
        end
    end

endmodule

// File: tb/tb_work_packer.sv
// Randomised self-checking bench for work_packer against a queue-based frame model.
module tb_work_packer;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_last;
    logic         in_ready;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [255:0] fifo_data;
    logic         frame_err;
    logic [15:0]  words_pushed;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0]  m_beats[$];
    bit           m_drop;
    logic [255:0] exp_q[$];
    int           exp_err;
    int           m_words;

    // observed traffic
    logic [255:0] obs_q[$];
    int           obs_err;
    int           viol;
    bit           rnd_done;

    work_packer dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .frame_err(frame_err),
        .words_pushed(words_pushed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (fifo_wr_en) begin
                obs_q.push_back(fifo_data);
                if (fifo_full) viol++;
            end
            if (frame_err) obs_err++;
        end
    end

    function automatic logic [31:0] place(input logic [31:0] d);
`ifdef WORK_PACKER_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    task automatic model_clear();
        m_beats.delete();
        m_drop = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_err = 0;
        obs_err = 0;
        m_words = 0;
        viol    = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic l);
        logic [255:0] w;
        if (m_drop) begin
            if (l) m_drop = 1'b0;
        end else begin
            m_beats.push_back(d);
            if (l) begin
                if (m_beats.size() == 8) begin
                    w = '0;
                    foreach (m_beats[i]) w = {w[223:0], place(m_beats[i])};
                    exp_q.push_back(w);
                    m_words++;
                end else begin
                    exp_err++;
                end
                m_beats.delete();
            end else if (m_beats.size() == 8) begin
                exp_err++;
                m_drop = 1'b1;
                m_beats.delete();
            end
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(d, l);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] base);
        for (int i = 0; i < 8; i++) send_beat(base + 32'(i), i == 7);
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        resetn    = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || fifo_wr_en !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b wr=%0b err=%0b, required 1 0 0", in_ready, fifo_wr_en, frame_err);
        end
        checks++;
        if (fifo_data !== 256'd0 || words_pushed !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h words=%0d, required 0 0", fifo_data, words_pushed);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        logic [255:0] w;
        do_reset();
        send_word(32'd0);
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[223:0], place(32'(i))};
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_data !== w) begin
            errors++;
            $display("FAIL basic_push: wr=%0b data=%h, required 1 %h", fifo_wr_en, fifo_data, w);
        end
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b0 || in_ready !== 1'b1 || words_pushed !== 16'd1) begin
            errors++;
            $display("FAIL basic_after: wr=%0b ready=%0b words=%0d, required 0 1 1", fifo_wr_en, in_ready, words_pushed);
        end
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes, required 1", obs_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] w;
        do_reset();
        @(posedge clk);
        #1 fifo_full = 1'b1;
        send_word(32'd0);
        w = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            checks++;
            if (in_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: ready=%0b wr=%0b, required 0 0", c, in_ready, fifo_wr_en);
            end
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_data !== w) begin
            errors++;
            $display("FAIL bp_release: wr=%0b data=%h, required 1 %h", fifo_wr_en, fifo_data, w);
        end
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || words_pushed !== 16'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_single: writes=%0d words=%0d ready=%0b, required 1 1 1", obs_q.size(), words_pushed, in_ready);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), i == 3);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (frame_err !== 1'b1 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL short_err: err=%0b wr=%0b, required 1 0", frame_err, fifo_wr_en);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: err=%0b, required 0", frame_err);
        end
        send_word($urandom);
        idle(3);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || words_pushed !== 16'd1 || obs_err != 1) begin
            errors++;
            $display("FAIL short_count: writes=%0d words=%0d errs=%0d, required 1 1 1", obs_q.size(), words_pushed, obs_err);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL short_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_long_frame();
        do_reset();
        for (int i = 0; i < 8; i++) send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b1);
        idle(2);
        checks++;
        if (obs_err != 1 || exp_err != 1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL long_err: errs=%0d writes=%0d, required 1 0", obs_err, obs_q.size());
        end
        send_word($urandom);
        idle(3);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || words_pushed !== 16'd1 || obs_err != 1) begin
            errors++;
            $display("FAIL long_next: writes=%0d words=%0d errs=%0d, required 1 1 1", obs_q.size(), words_pushed, obs_err);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL long_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) send_beat(32'hDEAD0000 + 32'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_data !== 256'd0 || in_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: data=%h ready=%0b wr=%0b, required 0 1 0", fifo_data, in_ready, fifo_wr_en);
        end
        resetn = 1'b1;
        model_clear();
        send_word(32'h100);
        idle(3);
        checks++;
        if (obs_q.size() != 1 || words_pushed !== 16'd1) begin
            errors++;
            $display("FAIL midrst_count: writes=%0d words=%0d, required 1 1", obs_q.size(), words_pushed);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL midrst_word: got %h, required %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_byteswap();
        logic [31:0] want;
`ifdef WORK_PACKER_BYTESWAP_EN
        want = 32'h44332211;
`else
        want = 32'h11223344;
`endif
        do_reset();
        send_beat(32'h11223344, 1'b0);
        for (int i = 1; i < 8; i++) send_beat($urandom, i == 7);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_data[255:224] !== want) begin
            errors++;
            $display("FAIL byteswap: wr=%0b msw=%h, required 1 %h", fifo_wr_en, fifo_data[255:224], want);
        end
    endtask

    task automatic test_random();
        int kind;
        int len;
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    kind = $urandom_range(0, 9);
                    if (kind < 7) begin
                        for (int i = 0; i < 8; i++) begin
                            if ($urandom_range(0, 3) == 0) idle(0);
                            send_beat($urandom, i == 7);
                        end
                    end else if (kind < 9) begin
                        len = $urandom_range(1, 7);
                        for (int i = 0; i < len; i++) send_beat($urandom, i == len - 1);
                    end else begin
                        len = 8 + $urandom_range(1, 3);
                        for (int i = 0; i < len; i++) send_beat($urandom, i == len - 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 fifo_full = ($urandom_range(0, 2) == 0);
                end
                fifo_full = 1'b0;
            end
        join
        idle(12);
        checks++;
        if (obs_q.size() != exp_q.size() || words_pushed !== m_words[15:0]) begin
            errors++;
            $display("FAIL rand_count: writes=%0d words=%0d, required %0d %0d", obs_q.size(), words_pushed, exp_q.size(), m_words);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_word%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (obs_err != exp_err || viol != 0) begin
            errors++;
            $display("FAIL rand_err: errs=%0d writes_while_full=%0d, required %0d 0", obs_err, viol, exp_err);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
        test_byteswap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
